// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite to block-RAM slave.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   state_t                 : transaction FSM states (read path, write path)
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        R_ISSUE,
        R_CAPT,
        R_RESP,
        W_NEED_W,
        W_NEED_AW,
        W_ISSUE,
        W_RESP
    } state_t;

endpackage

// File: rtl/bram_addr_decode.sv
// Combinational byte-address to BRAM word-index decoder.
//   addr     in  32          : AXI byte address
//   word     out ADDR_WIDTH  : word index, (addr - BASE_ADDR)[ADDR_WIDTH+1:2]
//   in_range out 1           : address falls inside the memory window
// Optional feature macro: AXI_RANGE_CHECK_EN. When undefined, in_range is
// tied high and addresses alias modulo the memory size.
module bram_addr_decode #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic [31:0]           addr,
    output logic [ADDR_WIDTH-1:0] word,
    output logic                  in_range
);

    // 32-bit wrapping subtraction: addresses below the base become huge
    // offsets and therefore fail the range check.
    logic [31:0] offset;
    assign offset = addr - BASE_ADDR;
    assign word   = offset[ADDR_WIDTH+1:2];

`ifdef AXI_RANGE_CHECK_EN
    localparam logic [32:0] MEM_BYTES = 33'd1 << (ADDR_WIDTH + 2);
    assign in_range = ({1'b0, offset} < MEM_BYTES);
`else
    assign in_range = 1'b1;
`endif

    // Byte-lane bits and (without the range check) the upper offset bits
    // carry no information for the word index.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:ADDR_WIDTH+2], offset[1:0]};

endmodule

// File: rtl/axi_lite_bram_slave.sv
// AXI4-Lite slave serving one transaction at a time from a single-port
// block RAM with one-cycle read latency.
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   axi_ar*/axi_r*     : read address / read data channels
//   axi_aw*/axi_w*/axi_b* : write address / write data / write response
//   bram_en/we/addr/wdata : BRAM access port (driven from registers)
//   bram_rdata         : BRAM read data, valid the cycle after a read enable
// Optional feature macro: AXI_RANGE_CHECK_EN (out-of-range -> SLVERR, no
// BRAM access). Default build aliases addresses and always returns OKAY.
module axi_lite_bram_slave
    import axi_lite_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           axi_araddr,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [2:0]            axi_arprot,
    output logic [31:0]           axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    input  logic [31:0]           axi_awaddr,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [2:0]            axi_awprot,
    input  logic [31:0]           axi_wdata,
    input  logic [3:0]            axi_wstrb,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    input  logic [31:0]           bram_rdata
);

    state_t                  state;
    logic                    ready_en;      // holds readies low until the first edge after reset
    logic [ADDR_WIDTH-1:0]   word_reg;      // AW captured ahead of W
    logic                    in_range_reg;  // range result of the transaction in flight
    logic [31:0]             wdata_reg;     // W captured ahead of AW
    logic [3:0]              wstrb_reg;

    // Decode whichever address can handshake this cycle: AW has priority,
    // and AR is only accepted when no AW is presented.
    logic [31:0]           dec_addr;
    logic [ADDR_WIDTH-1:0] dec_word;
    logic                  dec_in_range;

    assign dec_addr = axi_awvalid ? axi_awaddr : axi_araddr;

    bram_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decode (
        .addr     (dec_addr),
        .word     (dec_word),
        .in_range (dec_in_range)
    );

    // Readies may look at valids; writes win ties against reads.
    assign axi_awready = ready_en && (state == IDLE || state == W_NEED_AW);
    assign axi_wready  = ready_en && (state == IDLE || state == W_NEED_W);
    assign axi_arready = ready_en && (state == IDLE) && !axi_awvalid && !axi_wvalid;

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid  && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    // Write issue happens on the last of the AW/W handshakes; each half
    // comes from the live channel or from the earlier capture.
    logic                  issue_w;
    logic [ADDR_WIDTH-1:0] wr_word;
    logic                  wr_in_range;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;

    always_comb begin
        issue_w     = 1'b0;
        wr_word     = dec_word;
        wr_in_range = dec_in_range;
        wr_data     = axi_wdata;
        wr_strb     = axi_wstrb;
        case (state)
            IDLE:      issue_w = aw_hs && w_hs;
            W_NEED_W: begin
                issue_w     = w_hs;
                wr_word     = word_reg;
                wr_in_range = in_range_reg;
            end
            W_NEED_AW: begin
                issue_w = aw_hs;
                wr_data = wdata_reg;
                wr_strb = wstrb_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ready_en     <= 1'b0;
            word_reg     <= '0;
            in_range_reg <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            axi_rdata    <= '0;
            axi_rresp    <= RESP_OKAY;
            axi_rvalid   <= 1'b0;
            axi_bresp    <= RESP_OKAY;
            axi_bvalid   <= 1'b0;
            bram_en      <= 1'b0;
            bram_we      <= '0;
            bram_addr    <= '0;
            bram_wdata   <= '0;
        end else begin
            ready_en <= 1'b1;
            // The BRAM strobes are single-cycle pulses in the issue states.
            bram_en  <= 1'b0;
            bram_we  <= '0;

            if (issue_w) begin
                bram_en      <= wr_in_range;
                bram_we      <= wr_in_range ? wr_strb : 4'b0000;
                bram_addr    <= wr_word;
                bram_wdata   <= wr_data;
                in_range_reg <= wr_in_range;
                state        <= W_ISSUE;
            end else begin
                case (state)
                    IDLE: begin
                        if (aw_hs) begin
                            word_reg     <= dec_word;
                            in_range_reg <= dec_in_range;
                            state        <= W_NEED_W;
                        end else if (w_hs) begin
                            wdata_reg <= axi_wdata;
                            wstrb_reg <= axi_wstrb;
                            state     <= W_NEED_AW;
                        end else if (ar_hs) begin
                            bram_en      <= dec_in_range;
                            bram_addr    <= dec_word;
                            in_range_reg <= dec_in_range;
                            state        <= R_ISSUE;
                        end
                    end
                    R_ISSUE: state <= R_CAPT;
                    R_CAPT: begin
                        axi_rdata  <= in_range_reg ? bram_rdata : 32'h0;
                        axi_rresp  <= in_range_reg ? RESP_OKAY : RESP_SLVERR;
                        axi_rvalid <= 1'b1;
                        state      <= R_RESP;
                    end
                    R_RESP: begin
                        if (axi_rready) begin
                            axi_rvalid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    W_ISSUE: begin
                        axi_bresp  <= in_range_reg ? RESP_OKAY : RESP_SLVERR;
                        axi_bvalid <= 1'b1;
                        state      <= W_RESP;
                    end
                    W_RESP: begin
                        if (axi_bready) begin
                            axi_bvalid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= state;  // W_NEED_W / W_NEED_AW wait for the other channel
                endcase
            end
        end
    end

    logic unused_prot;
    assign unused_prot = ^{axi_arprot, axi_awprot};

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// Self-checking bench for axi_lite_bram_slave: directed sequences, a table
// of write/read vectors, and randomized traffic against a word-array model.
module tb_axi_lite_bram_slave;

    localparam int          AW        = 14;
    localparam int          WORDS     = 1 << AW;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [32:0] MEM_BYTES = 33'd1 << (AW + 2);
`ifdef AXI_RANGE_CHECK_EN
    localparam int RANGE_CHK = 1;
`else
    localparam int RANGE_CHK = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   axi_araddr = '0;
    logic          axi_arvalid = 1'b0;
    logic          axi_arready;
    logic [31:0]   axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rvalid;
    logic          axi_rready = 1'b0;
    logic [31:0]   axi_awaddr = '0;
    logic          axi_awvalid = 1'b0;
    logic          axi_awready;
    logic [31:0]   axi_wdata = '0;
    logic [3:0]    axi_wstrb = '0;
    logic          axi_wvalid = 1'b0;
    logic          axi_wready;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready = 1'b0;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;
    logic [31:0]   bram_rdata;

    axi_lite_bram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arprot(3'b000),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awprot(3'b000),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- BRAM behavioural model ----------------
    logic [31:0]   mem [0:WORDS-1];
    logic          mem_clr = 1'b0;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            en_cnt = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bram_en) en_cnt <= en_cnt + 1;
        if (mem_clr) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bram_en) begin
            if (bram_we == 4'b0000) begin
                bram_rdata <= mem[bram_addr];
                rd_cnt     <= rd_cnt + 1;
            end else begin
                mem[bram_addr] <= merge(mem[bram_addr], bram_wdata, bram_we);
                wr_cnt         <= wr_cnt + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:WORDS-1];

    function automatic logic ref_ok(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (RANGE_CHK != 0) return ({1'b0, off} < MEM_BYTES);
        return 1'b1;
    endfunction

    function automatic int ref_idx(input logic [31:0] addr);
        return int'(((addr - BASE) / 32'd4) % WORDS);
    endfunction

    function automatic logic [31:0] ref_rdata(input logic [31:0] addr);
        return ref_ok(addr) ? ref_mem[ref_idx(addr)] : 32'h0;
    endfunction

    function automatic logic [1:0] ref_resp(input logic [31:0] addr);
        return ref_ok(addr) ? 2'b00 : 2'b10;
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        int i;
        if (!ref_ok(addr)) return;
        i = ref_idx(addr);
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
    endtask

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic axi_read(input logic [31:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output logic en_seen, output logic stable);
        int n;
        data = '0; resp = '0; lat = -1; en_seen = 1'b0; stable = 1'b1;
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!axi_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!axi_arready) begin
            axi_arvalid = 1'b0;
            timeout_fail("ar_handshake");
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        en_seen = bram_en;
        lat = 0;
        while (!axi_rvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!axi_rvalid) begin
            timeout_fail("r_valid");
            return;
        end
        data = axi_rdata;
        resp = axi_rresp;
        for (int i = 0; i < rdelay; i++) begin
            @(posedge clk); #1;
            if (axi_rvalid !== 1'b1 || axi_rdata !== data || axi_rresp !== resp) stable = 1'b0;
        end
        axi_rready = 1'b1;
        @(posedge clk); #1;
        axi_rready = 1'b0;
        $display("txn read  addr=%h data=%h resp=%0d lat=%0d", addr, data, resp, lat);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int bdelay,
                             output logic [1:0] resp, output logic [3:0] we_seen, output int lat);
        bit aw_done, w_done, aw_hs, w_hs;
        int c;
        aw_done = 0; w_done = 0; c = 0;
        resp = '0; we_seen = '0; lat = -1;
        axi_awaddr = addr;
        axi_wdata  = d;
        axi_wstrb  = s;
        while (!(aw_done && w_done) && c < 60) begin
            axi_awvalid = !aw_done && (c >= aw_dly);
            axi_wvalid  = !w_done && (c >= w_dly);
            @(negedge clk);
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            c++;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout_fail("aw_w_handshake");
            return;
        end
        we_seen = bram_we;
        lat = 0;
        while (!axi_bvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!axi_bvalid) begin
            timeout_fail("b_valid");
            return;
        end
        resp = axi_bresp;
        repeat (bdelay) begin
            @(posedge clk); #1;
        end
        axi_bready = 1'b1;
        @(posedge clk); #1;
        axi_bready = 1'b0;
        $display("txn write addr=%h data=%h strb=%h resp=%0d we=%h lat=%0d",
                 addr, d, s, resp, we_seen, lat);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] data, a, d, exp_d;
    logic [1:0]  resp, exp_r;
    logic [3:0]  we, s;
    logic        en_s, stable, bstale;
    int          lat, c0, c1;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'hF, 32'h0, 2'b00};
        tbl[1] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hA5A5_5A5A, 2'b00};
        tbl[2] = '{1'b1, 32'h0000_0043, 32'h1234_5678, 4'h8, 32'h0, 2'b00};
        tbl[3] = '{1'b0, 32'h0000_0041, 32'h0,         4'h0, 32'h12A5_5A5A, 2'b00};
        tbl[4] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0, 2'b00};
        tbl[5] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h12A5_5A5A, 2'b00};
        tbl[6] = '{1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00};
        tbl[7] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};

        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        ref_mem[5] = 32'hDEAD_BEEF;

        // Reset, clear and preload the memory model.
        rst = 1'b1;
        mem_clr = 1'b1;
        @(posedge clk); #1;
        mem_clr  = 1'b0;
        pre_we   = 1'b1;
        pre_addr = AW'(5);
        pre_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        pre_we = 1'b0;

        chk("rst_awready", 32'(axi_awready), 32'd0);
        chk("rst_wready",  32'(axi_wready),  32'd0);
        chk("rst_arready", 32'(axi_arready), 32'd0);
        chk("rst_rvalid",  32'(axi_rvalid),  32'd0);
        chk("rst_bvalid",  32'(axi_bvalid),  32'd0);
        chk("rst_rdata",   axi_rdata,        32'd0);
        chk("rst_bram_en", 32'(bram_en),     32'd0);
        chk("rst_bram_we", 32'(bram_we),     32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);

        rst = 1'b0;
        #1;
        chk("post_rst_awready_low", 32'(axi_awready), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_awready", 32'(axi_awready), 32'd1);
        chk("post_rst_arready", 32'(axi_arready), 32'd1);

        // Single read of word 5.
        axi_read(32'h14, 0, data, resp, lat, en_s, stable);
        chk("rd5_data", data, 32'hDEAD_BEEF);
        chk("rd5_resp", 32'(resp), 32'd0);
        chk("rd5_lat", 32'(lat), 32'd2);
        chk("rd5_en_cycle1", 32'(en_s), 32'd1);

        // AW two cycles ahead of W, partial strobes.
        axi_write(32'h8, 32'h1122_3344, 4'b0101, 0, 2, 0, resp, we, lat);
        ref_write(32'h8, 32'h1122_3344, 4'b0101);
        chk("wr8_we", 32'(we), 32'h5);
        chk("wr8_lat", 32'(lat), 32'd1);
        chk("wr8_resp", 32'(resp), 32'd0);
        axi_read(32'h8, 0, data, resp, lat, en_s, stable);
        chk("wr8_readback", data, 32'h0022_0044);

        // W ahead of AW.
        axi_write(32'h0C, 32'h0BAD_F00D, 4'hF, 3, 0, 1, resp, we, lat);
        ref_write(32'h0C, 32'h0BAD_F00D, 4'hF);
        chk("wrc_lat", 32'(lat), 32'd1);
        axi_read(32'h0C, 0, data, resp, lat, en_s, stable);
        chk("wrc_readback", data, ref_rdata(32'h0C));

        // Tie: AR presented together with AW/W; the write must go first.
        c0 = rd_cnt;
        axi_araddr  = 32'h8;
        axi_arvalid = 1'b1;
        axi_write(32'h8, 32'hA0B0_C0D0, 4'hF, 0, 0, 0, resp, we, lat);
        ref_write(32'h8, 32'hA0B0_C0D0, 4'hF);
        chk("tie_no_early_read", 32'(rd_cnt - c0), 32'd0);
        axi_read(32'h8, 0, data, resp, lat, en_s, stable);
        chk("tie_read_after_write", data, 32'hA0B0_C0D0);

        // Back-pressure: rready low for 10 cycles.
        c0 = rd_cnt;
        axi_read(32'h14, 10, data, resp, lat, en_s, stable);
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_data", data, 32'hDEAD_BEEF);
        chk("bp_one_bram_read", 32'(rd_cnt - c0), 32'd1);

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, 0, 0, 0, resp, we, lat);
                ref_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
                chk($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(tbl[i].exp_resp));
            end else begin
                axi_read(tbl[i].addr, 0, data, resp, lat, en_s, stable);
                chk($sformatf("tbl%0d_rdata", i), data, tbl[i].exp_rdata);
                chk($sformatf("tbl%0d_rresp", i), 32'(resp), 32'(tbl[i].exp_resp));
            end
        end

        // Address one past the end of the memory window.
        exp_d = ref_rdata(32'h0001_0000);
        exp_r = ref_resp(32'h0001_0000);
        c0 = en_cnt;
        axi_read(32'h0001_0000, 0, data, resp, lat, en_s, stable);
        chk("range_rd_data", data, exp_d);
        chk("range_rd_resp", 32'(resp), 32'(exp_r));
        chk("range_rd_lat", 32'(lat), 32'd2);
        chk("range_rd_en_count", 32'(en_cnt - c0), (RANGE_CHK != 0) ? 32'd0 : 32'd1);
        c1 = wr_cnt;
        exp_r = ref_resp(32'h0001_0000);
        axi_write(32'h0001_0000, 32'h5555_AAAA, 4'hF, 0, 0, 0, resp, we, lat);
        ref_write(32'h0001_0000, 32'h5555_AAAA, 4'hF);
        chk("range_wr_resp", 32'(resp), 32'(exp_r));
        chk("range_wr_count", 32'(wr_cnt - c1), (RANGE_CHK != 0) ? 32'd0 : 32'd1);
        axi_read(32'h0, 0, data, resp, lat, en_s, stable);
        chk("range_word0", data, ref_rdata(32'h0));

        // Reset asserted during the write-issue cycle.
        axi_awaddr  = 32'h100;
        axi_wdata   = 32'h7777_7777;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        chk("rstw_we_before", 32'(bram_we), 32'hF);
        c1 = wr_cnt;
        rst = 1'b1;
        #1;
        chk("rstw_we_cleared", 32'(bram_we), 32'd0);
        chk("rstw_en_cleared", 32'(bram_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstw_no_bram_write", 32'(wr_cnt - c1), 32'd0);
        bstale = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (axi_bvalid) bstale = 1'b1;
        end
        chk("rstw_no_stale_bvalid", 32'(bstale), 32'd0);
        chk("rstw_awready_back", 32'(axi_awready), 32'd1);
        axi_read(32'h100, 0, data, resp, lat, en_s, stable);
        chk("rstw_word_unchanged", data, ref_rdata(32'h100));

        // Randomized traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(7, 0) == 0)
                a = 32'h0001_0000 + (32'($urandom_range(63, 0)) << 2);
            else
                a = (32'($urandom_range(63, 0)) << 2) + 32'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(15, 0));
                exp_r = ref_resp(a);
                axi_write(a, d, s, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                          int'($urandom_range(2, 0)), resp, we, lat);
                ref_write(a, d, s);
                chk("rand_bresp", 32'(resp), 32'(exp_r));
            end else begin
                exp_d = ref_rdata(a);
                exp_r = ref_resp(a);
                axi_read(a, int'($urandom_range(2, 0)), data, resp, lat, en_s, stable);
                chk("rand_rdata", data, exp_d);
                chk("rand_rresp", 32'(resp), 32'(exp_r));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_bram_slave.md
# axi_lite_bram_slave

AXI4-Lite slave that terminates the core's memory-side AXI master and serves requests from a single-port block RAM with one-cycle read latency. Sits directly downstream of the MMU's AXI port. Handles one transaction at a time: read or write, never both. Returns OKAY or SLVERR responses.

## Interface
Parameters:
- `ADDR_WIDTH`, 14, BRAM word-address width; memory size is 4·2^ADDR_WIDTH bytes.
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; must be aligned to the memory size.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `axi_araddr` in 32, `axi_arvalid` in 1, `axi_arready` out 1, `axi_arprot` in 3 — read address channel; prot ignored.
- `axi_rdata` out 32, `axi_rresp` out 2, `axi_rvalid` out 1, `axi_rready` in 1 — read data channel.
- `axi_awaddr` in 32, `axi_awvalid` in 1, `axi_awready` out 1, `axi_awprot` in 3 — write address channel; prot ignored.
- `axi_wdata` in 32, `axi_wstrb` in 4, `axi_wvalid` in 1, `axi_wready` out 1 — write data channel.
- `axi_bresp` out 2, `axi_bvalid` out 1, `axi_bready` in 1 — write response channel.
- `bram_en` out 1 — BRAM access enable.
- `bram_we` out 4 — per-byte write enable.
- `bram_addr` out ADDR_WIDTH — word address.
- `bram_wdata` out 32 — write data.
- `bram_rdata` in 32 — read data, valid on the cycle after `bram_en` with `bram_we`=0.

## Operation
FSM states:
- IDLE, R_ISSUE, R_CAPT, R_RESP — read path.
- W_NEED_W, W_NEED_AW, W_ISSUE, W_RESP — write path.

IDLE:
- `axi_awready` = `axi_wready` = 1.
- `axi_arready` = !`axi_awvalid` && !`axi_wvalid`. Writes win ties. Ready may depend on valid combinationally; valid never depends on ready.

Read path:
- AR handshake → capture address → R_ISSUE.
- R_ISSUE: drive `bram_en`=1, `bram_we`=0 → R_CAPT.
- R_CAPT: register `bram_rdata` into `axi_rdata` → R_RESP.
- R_RESP: `axi_rvalid`=1, data/resp stable until `axi_rready`; on handshake → IDLE.

Write path:
- AW and W are accepted independently; a captured channel drops its ready.
- Only AW handshaken → W_NEED_W (`axi_wready`=1).
- Only W handshaken → W_NEED_AW (`axi_awready`=1).
- Both captured (same or different cycles) → W_ISSUE.
- W_ISSUE: `bram_en`=1, `bram_we`=captured wstrb, wdata → W_RESP.
- W_RESP: `axi_bvalid`=1 until `axi_bready` → IDLE.

Address and response rules:
- Word index = (addr − BASE_ADDR)[ADDR_WIDTH+1:2]; addr[1:0] ignored, 32-bit wrap on subtraction.
- wstrb=0 is a legal write: `bram_we`=0, response OKAY.
- Outside R_ISSUE/W_ISSUE: `bram_en`=0, `bram_we`=0.
- Responses: OKAY=2'b00, SLVERR=2'b10.

## Timing
- Reset values: all ready/valid outputs 0, `axi_rdata`=0, resp outputs 0, all `bram_*`=0; state IDLE. Combinational readies come up 1 one cycle after reset deasserts.
- Read: AR handshake at edge 0 → `bram_en` in cycle 1 → `axi_rvalid` from cycle 3 (earliest). Next AR accepted the cycle after the R handshake.
- Write: last of AW/W handshakes at edge 0 → `bram_we` in cycle 1 → `axi_bvalid` from cycle 2.
- Back-pressure: a held `axi_rready`/`axi_bready`=0 stalls indefinitely with outputs stable.
- Reset mid-operation: transaction is discarded; no BRAM write may occur after reset asserts; no stale response after release.

## Configuration
`AXI_RANGE_CHECK_EN`:
- Defined: (addr − BASE_ADDR) ≥ 4·2^ADDR_WIDTH is out of range.
- Out-of-range read: the R_ISSUE cycle keeps `bram_en`=0; returns `axi_rdata`=0, `axi_rresp`=SLVERR.
- Out-of-range write: no BRAM write; `axi_bresp`=SLVERR. Latencies are unchanged.
- Undefined: no check; addresses alias modulo memory size; responses are always OKAY.

## Structure
- Package `axi_lite_pkg`: response constants RESP_OKAY/RESP_SLVERR, FSM state enum type.
- One sub-module, `bram_addr_decode` (combinational): outputs word index and in-range flag. The in-range flag is tied 1 without the macro.

## Test plan
- Single read: memory word 5 = 32'hDEAD_BEEF; AR 0x14 → rvalid at cycle 3 with rdata 32'hDEAD_BEEF, rresp 00.
- Write with AW two cycles before W: awaddr 0x8, wdata 32'h1122_3344, wstrb 4'b0101 → bram_we 0101 one cycle after the W handshake; bvalid next cycle; readback of an all-0 word gives 32'h0022_0044.
- Tie: arvalid and awvalid/wvalid asserted together → write completes first, then the read is accepted and returns post-write data.
- Back-pressure: rready held low 10 cycles → rvalid/rdata stable throughout; exactly one BRAM read.
- Range (macro defined, ADDR_WIDTH=14): AR 0x0001_0000 → rresp 10, rdata 0, bram_en never 1; write to the same address → bresp 10, no BRAM write. Macro undefined → aliases to word 0, OKAY.
- Reset asserted in W_ISSUE cycle → bram_we 0 immediately; after release no bvalid; IDLE readies return.
